backend_seq_ctrl: RTL and testbench

Parametrised successor to the analog-backend power-up controller. The block:
- loads per-channel gain codes from a serial config port;
- sequences the VCO reset release, then the reset release of each channel with a programmable stagger;
- asserts ready;
- measures the VCO frequency over a fixed reference-clock window, and re-measures on request.

It is fully synchronous to one clock. Serial clock and VCO clock are treated as asynchronous inputs and synchronised internally.

---
 rtl/backend_seq_pkg.sv | 20 ++
 rtl/edge_sync.sv | 26 ++
 rtl/backend_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_backend_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/backend_seq_pkg.sv
// Shared types and constants for the analog-backend power-up sequencer.
package backend_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVcoWait,
    StChRel,
    StRdyWait,
    StMeas,
    StDone
  } seq_state_e;

  localparam int unsigned SyncDepth = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, plus a one-cycle rising-edge pulse.
module edge_sync
  import backend_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic [SyncDepth-1:0] sync_q;
  logic                 last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], d_i};
      last_q <= sync_q[SyncDepth-1];
    end
  end

  assign pulse_o = sync_q[SyncDepth-1] & ~last_q;

endmodule

// File: rtl/backend_seq_ctrl.sv
// Power-up sequencer: serial gain load, staggered VCO/channel reset release, ready,
// then VCO frequency measurement over a fixed reference window with re-measure on request.
module backend_seq_ctrl
  import backend_seq_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned GAIN_W    = 3,
  parameter int unsigned VCO_DLY   = 2,
  parameter int unsigned CH_DLY    = 10,
  parameter int unsigned STAGGER   = 0,
  parameter int unsigned READY_DLY = 10,
  parameter int unsigned WIN       = 1024,
  parameter int unsigned CNT_W     = 12
) (
  input  logic                     i_clk,
  input  logic                     i_resetAll,
  input  logic                     i_sclk,
  input  logic                     i_sdin,
  input  logic                     i_vco_clk,
  input  logic                     i_remeasure,
  output logic                     o_ready,
  output logic                     o_resetb_vco,
  output logic [N_CH-1:0]          o_resetb_ch,
  output logic [N_CH*GAIN_W-1:0]   o_gain,
  output logic [CNT_W-1:0]         o_vco_count,
  output logic                     o_count_valid
);

  localparam int unsigned Bits   = N_CH * GAIN_W;
  localparam int unsigned BitW   = (Bits > 1) ? $clog2(Bits) : 1;
  localparam int unsigned DlyMax = max_u(max_u(VCO_DLY, CH_DLY + STAGGER * (N_CH - 1)),
                                         max_u(READY_DLY, WIN));
  localparam int unsigned DlyW   = $clog2(DlyMax + 1);

  localparam logic [BitW-1:0]  BitLast = BitW'(Bits - 1);
  localparam logic [DlyW-1:0]  VcoLast = DlyW'(VCO_DLY - 1);
  localparam logic [DlyW-1:0]  ChLast  = DlyW'(CH_DLY - 1 + STAGGER * (N_CH - 1));
  localparam logic [DlyW-1:0]  RdyLast = DlyW'(READY_DLY - 1);
  localparam logic [DlyW-1:0]  WinLast = DlyW'(WIN - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  seq_state_e           state_q;
  logic [Bits-1:0]      shreg_q;
  logic [BitW-1:0]      bit_idx_q;
  logic [DlyW-1:0]      dly_q;
  logic [CNT_W-1:0]     vcnt_q;
  logic [SyncDepth-1:0] sdin_sync_q;
  logic                 sclk_ev;
  logic                 vco_ev;
  logic                 sdin_s;

  edge_sync u_sclk_sync (
    .clk_i  (i_clk),
    .rst_i  (i_resetAll),
    .d_i    (i_sclk),
    .pulse_o(sclk_ev)
  );

  edge_sync u_vco_sync (
    .clk_i  (i_clk),
    .rst_i  (i_resetAll),
    .d_i    (i_vco_clk),
    .pulse_o(vco_ev)
  );

  // Data takes the same flop depth as the clock pulse, so it lines up with sclk_ev.
  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) sdin_sync_q <= '0;
    else            sdin_sync_q <= {sdin_sync_q[SyncDepth-2:0], i_sdin};
  end
  assign sdin_s = sdin_sync_q[SyncDepth-1];

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      dly_q         <= '0;
      vcnt_q        <= '0;
      o_ready       <= 1'b0;
      o_resetb_vco  <= 1'b0;
      o_resetb_ch   <= '0;
      o_gain        <= '0;
      o_vco_count   <= '0;
      o_count_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StLoad;
        StLoad: begin
          if (sclk_ev) begin
            shreg_q <= {sdin_s, shreg_q[Bits-1:1]};
            if (bit_idx_q == BitLast) begin
              o_gain    <= {sdin_s, shreg_q[Bits-1:1]};
              bit_idx_q <= '0;
              dly_q     <= '0;
              state_q   <= StVcoWait;
            end else begin
              bit_idx_q <= bit_idx_q + BitW'(1);
            end
          end
        end
        StVcoWait: begin
          if (dly_q == VcoLast) begin
            o_resetb_vco <= 1'b1;
            dly_q        <= '0;
            state_q      <= StChRel;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StChRel: begin
          for (int k = 0; k < int'(N_CH); k++) begin
            if (dly_q == DlyW'(CH_DLY - 1 + k * STAGGER)) o_resetb_ch[k] <= 1'b1;
          end
          if (dly_q == ChLast) begin
            dly_q   <= '0;
            state_q <= StRdyWait;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StRdyWait: begin
          if (dly_q == RdyLast) begin
            o_ready <= 1'b1;
            dly_q   <= '0;
            vcnt_q  <= CNT_W'(vco_ev);  // the window's first edge counts
            state_q <= StMeas;
          end else begin
            dly_q <= dly_q + DlyW'(1);
          end
        end
        StMeas: begin
          if (dly_q == WinLast) begin
            o_vco_count   <= vcnt_q;
            o_count_valid <= 1'b1;
            state_q       <= StDone;
          end else begin
            dly_q <= dly_q + DlyW'(1);
            if (vco_ev && vcnt_q != CntMax) vcnt_q <= vcnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (i_remeasure) begin
            o_count_valid <= 1'b0;
            dly_q         <= '0;
            vcnt_q        <= CNT_W'(vco_ev);
            state_q       <= StMeas;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_backend_seq_ctrl.sv
// Directed bench: default-parameter instance for load/timing/measure/reset, and a
// 4-channel staggered instance with a narrow counter for saturation and re-measure.
module tb_backend_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 20 MHz VCO against 100 MHz clk, offset so edges never coincide
  logic vco = 1'b0;
  initial begin
    #2;
    forever #25 vco = ~vco;
  end

  logic        rst_a = 1'b1, sclk_a = 1'b0, sdin_a = 1'b0, rem_a = 1'b0;
  logic        ready_a, rbv_a, val_a;
  logic [1:0]  rbc_a;
  logic [5:0]  gain_a;
  logic [11:0] cnt_a;

  logic        rst_b = 1'b1, sclk_b = 1'b0, sdin_b = 1'b0, rem_b = 1'b0;
  logic        ready_b, rbv_b, val_b;
  logic [3:0]  rbc_b;
  logic [11:0] gain_b;
  logic [5:0]  cnt_b;

  backend_seq_ctrl u_dut_a (
    .i_clk        (clk),
    .i_resetAll   (rst_a),
    .i_sclk       (sclk_a),
    .i_sdin       (sdin_a),
    .i_vco_clk    (vco),
    .i_remeasure  (rem_a),
    .o_ready      (ready_a),
    .o_resetb_vco (rbv_a),
    .o_resetb_ch  (rbc_a),
    .o_gain       (gain_a),
    .o_vco_count  (cnt_a),
    .o_count_valid(val_a)
  );

  backend_seq_ctrl #(
    .N_CH   (4),
    .STAGGER(3),
    .CNT_W  (6)
  ) u_dut_b (
    .i_clk        (clk),
    .i_resetAll   (rst_b),
    .i_sclk       (sclk_b),
    .i_sdin       (sdin_b),
    .i_vco_clk    (vco),
    .i_remeasure  (rem_b),
    .o_ready      (ready_b),
    .o_resetb_vco (rbv_b),
    .o_resetb_ch  (rbc_b),
    .o_gain       (gain_b),
    .o_vco_count  (cnt_b),
    .o_count_valid(val_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge-time monitors: cycle number of the latest 0->1 of each output bit
  logic [4:0]  mon_a, mon_a_q = '0;
  logic [6:0]  mon_b, mon_b_q = '0;
  logic [5:0]  gain_a_q = '0;
  logic [11:0] gain_b_q = '0;
  int t_a [5] = '{default: -1};
  int t_b [7] = '{default: -1};
  int t_gain_a = -1;
  int t_gain_b = -1;
  assign mon_a = {val_a, ready_a, rbc_a, rbv_a};
  assign mon_b = {val_b, ready_b, rbc_b, rbv_b};

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) if (mon_a[i] && !mon_a_q[i]) t_a[i] = cyc;
    for (int i = 0; i < 7; i++) if (mon_b[i] && !mon_b_q[i]) t_b[i] = cyc;
    if (gain_a != gain_a_q && gain_a != 6'd0) t_gain_a = cyc;
    if (gain_b != gain_b_q && gain_b != 12'd0) t_gain_b = cyc;
    mon_a_q  = mon_a;
    mon_b_q  = mon_b;
    gain_a_q = gain_a;
    gain_b_q = gain_b;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit sel, input logic b);
    @(negedge clk);
    if (sel) sdin_b = b; else sdin_a = b;
    repeat (2) @(negedge clk);
    if (sel) sclk_b = 1'b1; else sclk_a = 1'b1;
    repeat (6) @(negedge clk);
    if (sel) sclk_b = 1'b0; else sclk_a = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Final bit on A, followed by a second sclk rise landing in VCO_WAIT with flipped data
  task automatic send_last_dbl_a(input logic b);
    @(negedge clk);
    sdin_a = b;
    repeat (2) @(negedge clk);
    sclk_a = 1'b1;
    @(negedge clk);
    sclk_a = 1'b0;
    @(negedge clk);
    sdin_a = ~b;
    sclk_a = 1'b1;
    @(negedge clk);
    sclk_a = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [11:0] pat_b;
    int          e_b;
    pat_b = 12'h1D5;

    repeat (3) @(negedge clk);
    check_eq("a_rst_outs", {ready_a, rbv_a, rbc_a, val_a}, 0);
    check_eq("a_rst_gain", gain_a, 0);
    check_eq("b_rst_outs", {ready_b, rbv_b, rbc_b, val_b}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Default instance: load 1,0,0,1,1,0
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    check_eq("a_no_partial", gain_a, 0);
    send_last_dbl_a(1'b0);
    repeat (30) @(negedge clk);
    check_eq("a_gain", gain_a, 6'b011_001);
    check_eq("a_vco_rel", t_a[0] - t_gain_a, 2);
    check_eq("a_ch0_rel", t_a[1] - t_gain_a, 12);
    check_eq("a_ch1_rel", t_a[2] - t_gain_a, 12);
    check_eq("a_ready", t_a[3] - t_gain_a, 22);

    // Re-measure during MEAS must not restart the window
    rem_a = 1'b1;
    @(negedge clk);
    rem_a = 1'b0;
    repeat (1100) @(negedge clk);
    check_eq("a_valid_time", t_a[4] - t_a[3], 1024);
    check_eq("a_cnt_range", (cnt_a >= 12'd204 && cnt_a <= 12'd205), 1);
    check_eq("a_gain_hold", gain_a, 6'b011_001);
    check_eq("a_outs_done", {ready_a, rbv_a, rbc_a, val_a}, 5'b11111);

    // Asynchronous reset clears outputs between clock edges
    #2 rst_a = 1'b1;
    #1;
    check_eq("a_async_outs", {ready_a, rbv_a, rbc_a, val_a}, 0);
    check_eq("a_async_gain", gain_a, 0);
    check_eq("a_async_cnt", cnt_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    check_eq("a_no_residue", gain_a, 0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("a_reload_gain", gain_a, 6'b001_010);
    check_eq("a_reload_valid", val_a, 0);

    // Staggered instance: ch0=5, ch1=2, ch2=7, ch3=0
    for (int i = 0; i < 12; i++) send_bit(1, pat_b[i]);
    repeat (40) @(negedge clk);
    check_eq("b_gain", gain_b, 12'h1D5);
    check_eq("b_vco_rel", t_b[0] - t_gain_b, 2);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("b_ch%0d_rel", k), t_b[1+k] - t_gain_b, 12 + 3 * k);
    end
    check_eq("b_ready", t_b[5] - t_gain_b, 31);
    repeat (1100) @(negedge clk);
    check_eq("b_valid_time", t_b[6] - t_b[5], 1024);
    check_eq("b_sat_cnt", cnt_b, 63);

    // Re-measure from DONE
    rem_b = 1'b1;
    @(negedge clk);
    rem_b = 1'b0;
    e_b = cyc;
    check_eq("b_valid_drop", val_b, 0);
    check_eq("b_cnt_hold", cnt_b, 63);
    check_eq("b_ready_hold", ready_b, 1);
    repeat (1100) @(negedge clk);
    check_eq("b_revalid_time", t_b[6] - e_b, 1024);
    check_eq("b_recnt", cnt_b, 63);
    check_eq("b_gain_hold", gain_b, 12'h1D5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
